// File: rtl/dm_pkg.sv
// ---------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the data-memory access arbiter slice: default
// memory geometry, the arbiter FSM state encoding and an address range
// helper used to flag pipeline addresses that do not fit the DM.
// Ports: none (package).
// ---------------------------------------------------------------------------
package dm_pkg;

  localparam int DM_ADDR_W = 7;
  localparam int DM_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BUSY_PIPE = 2'd1,
    ST_BUSY_DMA  = 2'd2
  } dm_state_t;

  // True when any bit at or above position aw is set, i.e. the 32-bit
  // pipeline address does not fit in an aw-bit word address.
  function automatic logic addr_oob(input logic [31:0] addr, input int aw);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if ((i >= aw) && addr[i]) begin
        r = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dm_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// dm_access_arbiter_if
// Bundles the three buses around the arbiter: the MEM-stage port (pipe_*),
// the DMA/loader port (dma_*), the data-memory port (mem_*) and the sticky
// out-of-range flag.
// Modports:
//   slave  - the arbiter: takes requests and memory read data, drives
//            completions, stall, memory commands and err_oob.
//   master - the surrounding system (pipeline, DMA engine, DM array).
// ---------------------------------------------------------------------------
interface dm_access_arbiter_if
  import dm_pkg::*;
#(
  parameter int ADDR_W = DM_ADDR_W,
  parameter int DATA_W = DM_DATA_W
);

  // MEM pipeline stage
  logic              pipe_req;
  logic              pipe_we;
  logic [31:0]       pipe_addr;
  logic [DATA_W-1:0] pipe_wdata;
  logic [DATA_W-1:0] pipe_rdata;
  logic              pipe_done;
  logic              pipe_stall;

  // DMA / loader
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_done;

  // Data memory
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              err_oob;

  modport slave (
    input  pipe_req, pipe_we, pipe_addr, pipe_wdata,
    output pipe_rdata, pipe_done, pipe_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_done,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output err_oob
  );

  modport master (
    output pipe_req, pipe_we, pipe_addr, pipe_wdata,
    input  pipe_rdata, pipe_done, pipe_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_done,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  err_oob
  );

endinterface

// File: rtl/dm_lat_counter.sv
// ---------------------------------------------------------------------------
// dm_lat_counter
// Access-latency counter. Clear has priority over enable; last flags the
// final cycle of an access (count == LAT-1).
// Ports:
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-high reset (count -> 0)
//   clr  in  synchronous clear
//   en   in  increment enable
//   last out count has reached LAT-1
// ---------------------------------------------------------------------------
module dm_lat_counter #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  // Keep at least one bit so LAT=1 still elaborates; the count then stays 0
  // and every busy cycle is the last one.
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] LAST_VAL = CW'(LAT - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign last = (cnt_reg == LAST_VAL);

endmodule

// File: rtl/dm_access_arbiter.sv
// ---------------------------------------------------------------------------
// dm_access_arbiter
// Shares the single-port data memory between the MEM pipeline stage and a
// DMA/loader port. Each access holds the memory for LAT cycles; the
// requester sees done (and read data) in the last one. The pipeline has
// priority, but after STARVE_MAX consecutive pipeline grants with DMA
// waiting, the DMA port is forced through.
// Ports:
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  dm_access_arbiter_if.slave:
//          pipe_req/we/addr/wdata in, pipe_rdata/done/stall out
//          dma_req/we/addr/wdata  in, dma_rdata/done out
//          mem_req/we/addr/wdata  out, mem_rdata in
//          err_oob out (sticky pipeline address range error)
// ---------------------------------------------------------------------------
module dm_access_arbiter
  import dm_pkg::*;
#(
  parameter int ADDR_W     = DM_ADDR_W,
  parameter int DATA_W     = DM_DATA_W,
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  dm_access_arbiter_if.slave   bus
);

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  dm_state_t state_reg, state_next;

  logic              mem_req_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic [SW-1:0]     starve_cnt;
  logic              err_oob_reg;

  logic lat_clr, lat_en, lat_last;
  logic grant_pipe, grant_dma, forced;
  logic pipe_done, dma_done;

  dm_lat_counter #(.LAT(LAT)) u_lat (
    .clk  (clk),
    .rst  (rst),
    .clr  (lat_clr),
    .en   (lat_en),
    .last (lat_last)
  );

  // Next-state, grant and completion decode.
  always_comb begin
    state_next = state_reg;
    grant_pipe = 1'b0;
    grant_dma  = 1'b0;
    lat_clr    = 1'b1;
    lat_en     = 1'b0;
    pipe_done  = 1'b0;
    dma_done   = 1'b0;
    forced     = bus.dma_req && (starve_cnt == STARVE_LIM);

    case (state_reg)
      ST_IDLE: begin
        if (bus.pipe_req && !forced) begin
          grant_pipe = 1'b1;
          state_next = ST_BUSY_PIPE;
        end else if (bus.dma_req) begin
          grant_dma  = 1'b1;
          state_next = ST_BUSY_DMA;
        end
      end
      ST_BUSY_PIPE: begin
        lat_clr   = lat_last;
        lat_en    = !lat_last;
        pipe_done = lat_last;
        if (lat_last) begin
          state_next = ST_IDLE;
        end
      end
      ST_BUSY_DMA: begin
        lat_clr  = lat_last;
        lat_en   = !lat_last;
        dma_done = lat_last;
        if (lat_last) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Memory command registers: loaded from the winner on grant, held for the
  // whole access (late changes on the requester side are ignored), cleared
  // as the access ends so the IDLE cycle drives an inactive bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else if (grant_pipe) begin
      mem_req_reg   <= 1'b1;
      mem_we_reg    <= bus.pipe_we;
      mem_addr_reg  <= bus.pipe_addr[ADDR_W-1:0];
      mem_wdata_reg <= bus.pipe_wdata;
    end else if (grant_dma) begin
      mem_req_reg   <= 1'b1;
      mem_we_reg    <= bus.dma_we;
      mem_addr_reg  <= bus.dma_addr;
      mem_wdata_reg <= bus.dma_wdata;
    end else if ((state_reg != ST_IDLE) && lat_last) begin
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end
  end

  // Starvation counter: counts pipeline grants that overtook a waiting DMA
  // request; any cycle without a DMA request resets the streak.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!bus.dma_req || grant_dma) begin
      starve_cnt <= '0;
    end else if (grant_pipe && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Out-of-range pipeline address: the access still goes ahead on the
  // truncated address; the flag only records that it happened.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_oob_reg <= 1'b0;
    end else if (grant_pipe && addr_oob(bus.pipe_addr, ADDR_W)) begin
      err_oob_reg <= 1'b1;
    end
  end

  assign bus.pipe_done  = pipe_done;
  assign bus.pipe_rdata = pipe_done ? bus.mem_rdata : '0;
  assign bus.pipe_stall = bus.pipe_req && !pipe_done;
  assign bus.dma_done   = dma_done;
  assign bus.dma_rdata  = dma_done ? bus.mem_rdata : '0;
  assign bus.mem_req    = mem_req_reg;
  assign bus.mem_we     = mem_we_reg;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.mem_wdata  = mem_wdata_reg;
  assign bus.err_oob    = err_oob_reg;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dm_access_arbiter
// Directed bench: instance A (LAT=2, STARVE_MAX=4) and instance B (LAT=1),
// each with a behavioural data memory that commits writes in the last
// cycle of an access.
// ---------------------------------------------------------------------------
module tb_dm_access_arbiter;

  logic clk;
  logic rst;

  int n_checks;
  int n_pass;

  dm_access_arbiter_if #(.ADDR_W(7), .DATA_W(32)) bus_a ();
  dm_access_arbiter_if #(.ADDR_W(7), .DATA_W(32)) bus_b ();

  dm_access_arbiter #(.ADDR_W(7), .DATA_W(32), .LAT(2), .STARVE_MAX(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  dm_access_arbiter #(.ADDR_W(7), .DATA_W(32), .LAT(1), .STARVE_MAX(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural DM for A: LAT=2, write lands at the end of the 2nd cycle.
  logic [31:0] mem_a [128];
  int          cyc_a;
  assign bus_a.mem_rdata = mem_a[bus_a.mem_addr];
  always @(posedge clk) begin
    if (rst) begin
      cyc_a <= 0;
    end else if (bus_a.mem_req) begin
      if (cyc_a == 1) begin
        if (bus_a.mem_we) mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
        cyc_a <= 0;
      end else begin
        cyc_a <= cyc_a + 1;
      end
    end else begin
      cyc_a <= 0;
    end
  end

  // Behavioural DM for B: LAT=1, every active cycle is the commit cycle.
  logic [31:0] mem_b [128];
  int          wr_b;
  assign bus_b.mem_rdata = mem_b[bus_b.mem_addr];
  always @(posedge clk) begin
    if (rst) begin
      wr_b <= 0;
    end else if (bus_b.mem_req && bus_b.mem_we) begin
      mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;
      wr_b <= wr_b + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      n_pass++;
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // One pipeline access on A; stalls counts cycles with pipe_stall=1.
  task automatic pipe_a(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output int stalls, output logic [31:0] maddr);
    logic seen;
    seen   = 1'b0;
    stalls = 0;
    rd     = '0;
    maddr  = '0;
    @(posedge clk); #1;
    bus_a.pipe_req   = 1'b1;
    bus_a.pipe_we    = we;
    bus_a.pipe_addr  = addr;
    bus_a.pipe_wdata = wd;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_a.pipe_stall) stalls++;
      if (bus_a.pipe_done) begin
        rd    = bus_a.pipe_rdata;
        maddr = 32'(bus_a.mem_addr);
        seen  = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!seen) check({tag, "_timeout"}, 32'(seen), 32'd1);
    @(posedge clk); #1;
    bus_a.pipe_req = 1'b0;
    bus_a.pipe_we  = 1'b0;
  endtask

  // One DMA access on A; cycles counts sampled cycles up to and including done.
  task automatic dma_a(input string tag, input logic we, input logic [6:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output int cycles);
    logic seen;
    seen   = 1'b0;
    cycles = 0;
    rd     = '0;
    @(posedge clk); #1;
    bus_a.dma_req   = 1'b1;
    bus_a.dma_we    = we;
    bus_a.dma_addr  = addr;
    bus_a.dma_wdata = wd;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cycles++;
      if (bus_a.dma_done) begin
        rd   = bus_a.dma_rdata;
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!seen) check({tag, "_timeout"}, 32'(seen), 32'd1);
    @(posedge clk); #1;
    bus_a.dma_req = 1'b0;
    bus_a.dma_we  = 1'b0;
  endtask

  logic [31:0] rd;
  logic [31:0] maddr;
  int          nst;
  int          ncyc;
  int          tp, td, np;
  logic        got;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus_a.pipe_req = 0; bus_a.pipe_we = 0; bus_a.pipe_addr = 0; bus_a.pipe_wdata = 0;
    bus_a.dma_req  = 0; bus_a.dma_we  = 0; bus_a.dma_addr  = 0; bus_a.dma_wdata  = 0;
    bus_b.pipe_req = 0; bus_b.pipe_we = 0; bus_b.pipe_addr = 0; bus_b.pipe_wdata = 0;
    bus_b.dma_req  = 0; bus_b.dma_we  = 0; bus_b.dma_addr  = 0; bus_b.dma_wdata  = 0;

    // Reset state
    #2;
    check("rst_mem_req",   32'(bus_a.mem_req),   32'd0);
    check("rst_mem_we",    32'(bus_a.mem_we),    32'd0);
    check("rst_pipe_done", 32'(bus_a.pipe_done), 32'd0);
    check("rst_dma_done",  32'(bus_a.dma_done),  32'd0);
    check("rst_err_oob",   32'(bus_a.err_oob),   32'd0);
    check("rst_state",     32'(dut_a.state_reg), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Preload through the DMA port
    dma_a("pre5", 1'b1, 7'd5, 32'hDEAD_BEEF, rd, ncyc);
    check("dma_wr_cycles", 32'(ncyc), 32'd3);
    dma_a("pre7", 1'b1, 7'd7, 32'h7777_0007, rd, ncyc);
    dma_a("pre9", 1'b1, 7'd9, 32'hAAAA_5555, rd, ncyc);
    check("pre_mem9", mem_a[9], 32'hAAAA_5555);
    dma_a("rd7", 1'b0, 7'd7, 32'h0, rd, ncyc);
    check("dma_rd7", rd, 32'h7777_0007);

    // Pipeline load addr 5: two stall cycles then done with the data
    pipe_a("ld5", 1'b0, 32'd5, 32'h0, rd, nst, maddr);
    check("ld5_rdata",  rd, 32'hDEAD_BEEF);
    check("ld5_stalls", 32'(nst), 32'd2);
    @(negedge clk);
    check("ld5_idle_after", 32'(bus_a.mem_req), 32'd0);

    // Simultaneous requests: pipeline first, DMA done LAT+1 cycles later
    @(posedge clk); #1;
    bus_a.pipe_req = 1'b1; bus_a.pipe_we = 1'b0; bus_a.pipe_addr = 32'd5;
    bus_a.dma_req  = 1'b1; bus_a.dma_we  = 1'b0; bus_a.dma_addr  = 7'd7;
    tp = -1; td = -1;
    for (int c = 0; c < 30 && (tp < 0 || td < 0); c++) begin
      @(negedge clk);
      if (bus_a.pipe_done && tp < 0) begin
        tp = c;
        check("sim_pipe_rdata", bus_a.pipe_rdata, 32'hDEAD_BEEF);
      end
      if (bus_a.dma_done && td < 0) begin
        td = c;
        check("sim_dma_rdata", bus_a.dma_rdata, 32'h7777_0007);
      end
      @(posedge clk); #1;
      if (tp >= 0) bus_a.pipe_req = 1'b0;
      if (td >= 0) bus_a.dma_req  = 1'b0;
    end
    bus_a.pipe_req = 1'b0;
    bus_a.dma_req  = 1'b0;
    check("sim_pipe_first", 32'((tp >= 0) && (td > tp)), 32'd1);
    check("sim_gap", 32'(td - tp), 32'd3);

    // Starvation: DMA held, pipeline always requesting
    @(posedge clk); #1;
    bus_a.pipe_req = 1'b1; bus_a.pipe_we = 1'b0; bus_a.pipe_addr = 32'd5;
    bus_a.dma_req  = 1'b1; bus_a.dma_we  = 1'b0; bus_a.dma_addr  = 7'd9;
    np = 0; got = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus_a.pipe_done) np++;
      if (bus_a.dma_done) begin
        got = 1'b1;
        check("stv_dma_rdata", bus_a.dma_rdata, 32'hAAAA_5555);
        check("stv_cnt_zero",  32'(dut_a.starve_cnt), 32'd0);
        check("stv_pipe_wait", 32'(bus_a.pipe_stall), 32'd1);
        break;
      end
      @(posedge clk); #1;
    end
    check("stv_dma_seen",    32'(got), 32'd1);
    check("stv_pipe_grants", 32'(np),  32'd4);
    @(posedge clk); #1;
    bus_a.pipe_req = 1'b0;
    bus_a.dma_req  = 1'b0;

    // Reset during a pipeline store to addr 9
    @(posedge clk); #1;
    bus_a.pipe_req = 1'b1; bus_a.pipe_we = 1'b1;
    bus_a.pipe_addr = 32'd9; bus_a.pipe_wdata = 32'h0000_1234;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstmid_busy_we", 32'(bus_a.mem_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_mem_we",   32'(bus_a.mem_we),    32'd0);
    check("rstmid_mem_req",  32'(bus_a.mem_req),   32'd0);
    check("rstmid_done",     32'(bus_a.pipe_done), 32'd0);
    check("rstmid_state",    32'(dut_a.state_reg), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus_a.pipe_req = 1'b0;
    bus_a.pipe_we  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstmid_mem9", mem_a[9], 32'hAAAA_5555);

    // Out-of-range pipeline store 0x85 -> addr 5, sticky flag
    pipe_a("oob", 1'b1, 32'h85, 32'hCAFE_0001, rd, nst, maddr);
    check("oob_addr",   maddr, 32'd5);
    check("oob_flag",   32'(bus_a.err_oob), 32'd1);
    check("oob_mem5",   mem_a[5], 32'hCAFE_0001);
    pipe_a("ld5b", 1'b0, 32'd5, 32'h0, rd, nst, maddr);
    check("oob_rd5",    rd, 32'hCAFE_0001);
    check("oob_sticky", 32'(bus_a.err_oob), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("oob_rst_clr", 32'(bus_a.err_oob), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // LAT=1 back-to-back pipeline stores on B
    @(posedge clk); #1;
    bus_b.pipe_req = 1'b1; bus_b.pipe_we = 1'b1;
    bus_b.pipe_addr = 32'd1; bus_b.pipe_wdata = 32'h11;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("l1_idle_req%0d", k),   32'(bus_b.mem_req),    32'd0);
      check($sformatf("l1_idle_stall%0d", k), 32'(bus_b.pipe_stall), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("l1_done%0d", k),  32'(bus_b.pipe_done),  32'd1);
      check($sformatf("l1_nostl%0d", k), 32'(bus_b.pipe_stall), 32'd0);
      @(posedge clk); #1;
      if (k < 3) begin
        bus_b.pipe_addr  = 32'(k + 1);
        bus_b.pipe_wdata = 32'(17 * (k + 1));
      end else begin
        bus_b.pipe_req = 1'b0;
        bus_b.pipe_we  = 1'b0;
      end
    end
    @(negedge clk);
    check("l1_writes", 32'(wr_b), 32'd3);
    check("l1_mem1", mem_b[1], 32'h11);
    check("l1_mem2", mem_b[2], 32'h22);
    check("l1_mem3", mem_b[3], 32'h33);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global bound in case a handshake never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
